hud_number_renderer: RTL and testbench

- Multi-field HUD number renderer. Generalises the fixed score/level overlay to N_FIELDS independent decimal fields, each with DIGITS digits, a runtime position and a runtime enable.
- Replaces per-pixel combinational int-to-digit conversion with one shared, time-multiplexed double-dabble converter. The converter runs once per frame and feeds frame-stable digit registers.
- Renders from the shared 10x10 12-bit glyph set, with a registered pixel output. Sits between the game-state logic and the VGA pixel mux.

---
 rtl/hud_number_renderer.sv | 232 +++++++++++++++++++++++
 tb/tb_hud_number_renderer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hud_number_renderer.sv
// Multi-field HUD number renderer: one shared double-dabble converter per frame feeding
// frame-stable digit registers, rendered from a 10x10 segment glyph set. Option: HUD_CHANGE_FLASH_EN.
`timescale 1ns/1ps
module hud_number_renderer #(
  parameter int unsigned N_FIELDS     = 2,
  parameter int unsigned DIGITS       = 7,
  parameter int unsigned VALUE_W      = 24,
  parameter int unsigned SPACING      = 15,
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   h_count,
  input  logic [9:0]                   v_count,
  input  logic [N_FIELDS*VALUE_W-1:0]  value,
  input  logic [N_FIELDS*10-1:0]       field_x,
  input  logic [N_FIELDS*10-1:0]       field_y,
  input  logic [N_FIELDS-1:0]          field_en,
  output logic [11:0]                  rgb,
  output logic                         drawing,
  output logic                         busy
);

  localparam int unsigned IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
  localparam int unsigned BCD_W = DIGITS * 4;
  localparam logic [11:0] GLYPH_RGB = 12'hFF0;
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

  function automatic logic [63:0] max_value();
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value();

  // Count of suppressed leading zeros; the least significant digit is never suppressed.
  function automatic int unsigned lead_zeros(input logic [BCD_W-1:0] d);
    int unsigned n;
    n = 0;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      if (n == DIGITS - 1 - i && d[i*4 +: 4] == 4'd0) n++;
    end
    return n;
  endfunction

  // Seven-segment style glyphs: a=top, b/c=right, d=bottom, e/f=left, g=middle (row 5).
  function automatic logic [11:0] glyph_pixel(input logic [3:0] digit, input logic [3:0] row,
                                              input logic [3:0] col);
    logic [6:0] seg;
    logic       on;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = '0;
    endcase
    on = (seg[0] && row == 4'd0 && col >= 4'd2 && col <= 4'd7) ||
         (seg[1] && col == 4'd8 && row >= 4'd1 && row <= 4'd4) ||
         (seg[2] && col == 4'd8 && row >= 4'd6 && row <= 4'd8) ||
         (seg[3] && row == 4'd9 && col >= 4'd2 && col <= 4'd7) ||
         (seg[4] && col == 4'd1 && row >= 4'd6 && row <= 4'd8) ||
         (seg[5] && col == 4'd1 && row >= 4'd1 && row <= 4'd4) ||
         (seg[6] && row == 4'd5 && col >= 4'd2 && col <= 4'd7);
    return on ? GLYPH_RGB : '0;
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, NEXT, COMMIT} state_t;

  state_t             state, state_nx;
  logic               at_origin, at_origin_q, frame_start;
  logic [VALUE_W-1:0] bin, cur_val;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic               sat;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   shift_cnt;
  logic [BCD_W-1:0]   shadow [N_FIELDS];
  logic [BCD_W-1:0]   disp   [N_FIELDS];
  logic [N_FIELDS-1:0] blank;
  logic               hit;
  logic [3:0]         hit_digit, hit_row, hit_col;
  logic [11:0]        glyph_px;

  assign at_origin = (h_count == '0) && (v_count == '0);
  assign cur_val   = value[idx*VALUE_W +: VALUE_W];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      at_origin_q <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      at_origin_q <= at_origin;
      frame_start <= at_origin && !at_origin_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (shift_cnt == CNT_W'(VALUE_W - 1)) state_nx = STORE;
      STORE:   state_nx = NEXT;
      NEXT:    state_nx = (idx == IDX_W'(N_FIELDS - 1)) ? COMMIT : LOAD;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      bcd_adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin       <= '0;
      bcd       <= '0;
      sat       <= 1'b0;
      idx       <= '0;
      shift_cnt <= '0;
      for (int unsigned f = 0; f < N_FIELDS; f++) begin
        shadow[f] <= '0;
        disp[f]   <= '0;
      end
    end else begin
      case (state)
        IDLE: idx <= '0;
        LOAD: begin
          bin       <= cur_val;
          bcd       <= '0;
          sat       <= (64'(cur_val) > MAX_VAL);
          shift_cnt <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          shift_cnt  <= shift_cnt + 1'b1;
        end
        STORE: shadow[idx] <= sat ? NINES : bcd;
        NEXT:  if (idx != IDX_W'(N_FIELDS - 1)) idx <= idx + 1'b1;
        COMMIT: for (int unsigned f = 0; f < N_FIELDS; f++) disp[f] <= shadow[f];
        default: ;
      endcase
    end
  end

`ifdef HUD_CHANGE_FLASH_EN
  localparam int unsigned FL_W = ($clog2(FLASH_FRAMES + 1) > 3) ? $clog2(FLASH_FRAMES + 1) : 3;
  logic [FL_W-1:0] flash_cnt [N_FIELDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned f = 0; f < N_FIELDS; f++) flash_cnt[f] <= '0;
    end else begin
      for (int unsigned f = 0; f < N_FIELDS; f++) begin
        if (state == COMMIT && shadow[f] != disp[f])
          flash_cnt[f] <= FL_W'(FLASH_FRAMES);
        else if (frame_start && flash_cnt[f] != '0)
          flash_cnt[f] <= flash_cnt[f] - 1'b1;
      end
    end
  end

  always_comb begin
    blank = '0;
    for (int unsigned f = 0; f < N_FIELDS; f++)
      blank[f] = (flash_cnt[f] != '0) && flash_cnt[f][2];
  end
`else
  assign blank = '0;
`endif

  // Significant digits are left-packed; cells past column 1023 cannot match a 10-bit counter.
  always_comb begin : hit_test
    logic [15:0] fx, fy, cx, hx, vy;
    int unsigned lead, pos;
    hit       = 1'b0;
    hit_digit = '0;
    hit_row   = '0;
    hit_col   = '0;
    fx = '0; fy = '0; cx = '0; lead = 0; pos = 0;
    hx = 16'(h_count);
    vy = 16'(v_count);
    for (int unsigned f = 0; f < N_FIELDS; f++) begin
      fx   = 16'(field_x[f*10 +: 10]);
      fy   = 16'(field_y[f*10 +: 10]);
      lead = lead_zeros(disp[f]);
      if (!hit && field_en[f] && !blank[f] && vy >= fy && vy < fy + 16'd10) begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          cx = fx + 16'(k * SPACING);
          if (!hit && k < DIGITS - lead && hx >= cx && hx < cx + 16'd10) begin
            pos       = DIGITS - 1 - lead - k;
            hit       = 1'b1;
            hit_digit = disp[f][pos*4 +: 4];
            hit_row   = 4'(vy - fy);
            hit_col   = 4'(hx - cx);
          end
        end
      end
    end
  end

  assign glyph_px = glyph_pixel(hit_digit, hit_row, hit_col);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb     <= '0;
      drawing <= 1'b0;
    end else begin
      drawing <= hit && (glyph_px != '0);
      rgb     <= hit ? glyph_px : '0;
    end
  end

endmodule

// File: tb/tb_hud_number_renderer.sv
// Directed bench for hud_number_renderer: expected pixels are queued when a probe is
// driven and popped when the registered output is sampled one cycle later.
`timescale 1ns/1ps
module tb_hud_number_renderer;

  localparam logic [11:0] GLYPH_RGB = 12'hFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count, v_count;
  logic [47:0] value;
  logic [19:0] field_x, field_y;
  logic [1:0]  field_en;
  logic [11:0] rgb;
  logic        drawing, busy;

  int tests = 0;
  int fails = 0;
  int n;

  typedef struct {
    string       tag;
    logic        draw;
    logic [11:0] rgb;
  } exp_t;
  exp_t sb[$];

  hud_number_renderer #(
    .N_FIELDS(2), .DIGITS(7), .VALUE_W(24), .SPACING(15), .FLASH_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count), .value(value),
    .field_x(field_x), .field_y(field_y), .field_en(field_en),
    .rgb(rgb), .drawing(drawing), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input int h, input int v, input bit on);
    exp_t e;
    e.tag  = tag;
    e.draw = on;
    e.rgb  = on ? GLYPH_RGB : 12'h000;
    sb.push_back(e);
    h_count = 10'(h);
    v_count = 10'(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, "_draw"}, 32'(drawing), 32'(e.draw));
    chk({e.tag, "_rgb"}, 32'(rgb), 32'(e.rgb));
  endtask

  // Pulses the origin, optionally changes value0 or revisits the origin mid-sequence,
  // and returns how many sampled cycles busy was high.
  task automatic run_frame(input int hold, input int chg_at, input logic [23:0] chg_val,
                           input int reorigin_at, output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen = 1'b0;
    h_count = 10'd0;
    v_count = 10'd0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        busy_cycles++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      if (i == hold)        begin h_count = 10'd600; v_count = 10'd600; end
      if (i == chg_at)      value[23:0] = chg_val;
      if (i == reorigin_at) begin h_count = 10'd0; v_count = 10'd0; end
      if (i == reorigin_at + 1) begin h_count = 10'd600; v_count = 10'd600; end
    end
  endtask

  initial begin
    reset    = 1'b0;
    value    = {24'd0, 24'd1234};
    field_x  = {10'd100, 10'd100};
    field_y  = {10'd80, 10'd50};
    field_en = 2'b01;
    h_count  = 10'd500;
    v_count  = 10'd500;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_drawing", 32'(drawing), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    probe("rst_zero_top", 104, 50, 1'b1);
    probe("rst_zero_mid", 104, 55, 1'b0);
    probe("rst_one_glyph", 119, 50, 1'b0);
    chk("idle_busy", 32'(busy), 32'h0);

    // 1234 -> four left-packed glyphs
    run_frame(1, -1, 24'd0, -1, n);
    chk("busy_len_1234", 32'(n), 32'd55);
    probe("d0_1_top", 104, 50, 1'b0);
    probe("d0_1_b", 108, 52, 1'b1);
    probe("d1_2_e", 116, 57, 1'b1);
    probe("d2_3_e", 131, 57, 1'b0);
    probe("d2_3_top", 134, 50, 1'b1);
    probe("d3_4_top", 149, 50, 1'b0);
    probe("d3_4_mid", 149, 55, 1'b1);
    probe("d4_blank", 164, 50, 1'b0);
    probe("cell_corner", 100, 50, 1'b0);
    probe("f1_disabled", 104, 80, 1'b0);

    // Saturation of field 1
    value[47:24] = 24'd16777215;
    field_en     = 2'b11;
    run_frame(1, -1, 24'd0, -1, n);
    chk("busy_len_sat", 32'(n), 32'd55);
    probe("sat_k0_top", 104, 80, 1'b1);
    probe("sat_k0_e", 101, 87, 1'b0);
    probe("sat_k6_top", 194, 80, 1'b1);
    probe("sat_k6_mid", 194, 85, 1'b1);
    probe("sat_k7_none", 209, 80, 1'b0);
    probe("f0_kept", 108, 52, 1'b1);

    // Overlap: field 1 moved onto field 0
    field_y[19:10] = 10'd50;
    value[47:24]   = 24'd7777777;
    run_frame(1, -1, 24'd0, -1, n);
    chk("busy_len_ovl", 32'(n), 32'd55);
    probe("ovl_f0_wins_off", 104, 50, 1'b0);
    probe("ovl_f0_on", 116, 57, 1'b1);
    probe("ovl_f1_beyond_f0", 194, 50, 1'b1);
    field_en = 2'b10;
    probe("ovl_f1_top", 104, 50, 1'b1);
    probe("ovl_f1_e", 116, 57, 1'b0);

    // value sampled at LOAD only; frame_start while busy is ignored
    field_en    = 2'b01;
    value[23:0] = 24'd5;
    run_frame(5, 8, 24'd8, 20, n);
    chk("busy_len_hold", 32'(n), 32'd55);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_rerun", 32'(busy), 32'h0);
    end
    probe("ld_5_top", 104, 50, 1'b1);
    probe("ld_5_b", 108, 52, 1'b0);

    // Value change shows steadily in the default build
    value[23:0] = 24'd6;
    run_frame(1, -1, 24'd0, -1, n);
    probe("chg_6_e", 101, 57, 1'b1);
    run_frame(1, -1, 24'd0, -1, n);
    probe("steady_6_e", 101, 57, 1'b1);

    // Reset mid-conversion
    h_count = 10'd0;
    v_count = 10'd0;
    @(posedge clk); #1;
    h_count = 10'd600;
    v_count = 10'd600;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    probe("mid_rst_zero_b", 108, 52, 1'b1);
    probe("mid_rst_zero_mid", 104, 55, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
